jtopl_timing: RTL and testbench

Parametrised timing generator for the OPL core: one block replaces the separate clock-enable divider and slot counter. It derives the chip clock enable `cen` and the operator-rate enable `cenop` from `clk` with configurable ratios. It walks a configurable number of operator groups, and publishes the current slot as both an index and a one-hot vector. All slot-indexed pipelines (EG, PG, OP) consume its outputs, and `halt` adds a freeze mode for single-stepping benches.

---
 rtl/jtopl_pkg.sv | 9 +
 rtl/jtopl_timing_div.sv | 24 ++
 rtl/jtopl_timing.sv | 77 +++++++
 tb/tb_jtopl_timing.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// jtopl_pkg: shared slot-geometry constants and the (group, subslot) -> slot index map
package jtopl_pkg;
    localparam int SUBSLOTS = 6;
    localparam int OPL2_GROUPS = 3;
    localparam int OPL3_GROUPS = 6;
    function automatic int slot_index(input logic [2:0] grp, input logic [2:0] sub);
        return int'(grp) * SUBSLOTS + int'(sub);
    endfunction
endpackage

// File: rtl/jtopl_timing_div.sv
// jtopl_timing_div: modulo-N enable divider, counts in_en pulses and flags the last one
// Ports: clk, rst (async, active-high), halt (freeze count), in_en (count enable),
//        out_en (in_en on the count that wraps; combinational from the held count)
module jtopl_timing_div #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic halt,
    input  logic in_en,
    output logic out_en
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    logic last;
    always_comb begin
        last = cnt_q == W'(N - 1);
        cnt_d = (in_en && !halt) ? (last ? '0 : cnt_q + W'(1)) : cnt_q;
    end
    assign out_en = in_en && last;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/jtopl_timing.sv
// jtopl_timing: OPL clock-enable divider and slot walker with halt freeze
// Ports: clk, rst (async, active-high), halt (freeze) in; cen, cenop, zero, group,
//        subslot, op, slot (one-hot) out; sample (frame counter) only with JTOPL_TIMING_SAMPLE_EN
module jtopl_timing import jtopl_pkg::*; #(
    parameter int GROUPS = OPL2_GROUPS,
    parameter int CENDIV = 2,
    parameter int OPDIV  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         halt,
    output logic                         cen,
    output logic                         cenop,
    output logic                         zero,
    output logic [2:0]                   group,
    output logic [2:0]                   subslot,
    output logic                         op,
    output logic [SUBSLOTS*GROUPS-1:0]   slot
`ifdef JTOPL_TIMING_SAMPLE_EN
    ,
    output logic [15:0]                  sample
`endif
);
    localparam int SLOTS = SUBSLOTS * GROUPS;
    if (GROUPS < 1 || GROUPS > 6 || CENDIV < 1 || OPDIV < 1) begin : g_bad_param
        $error("jtopl_timing: GROUPS must be 1..6, CENDIV and OPDIV >= 1");
    end
    logic cdiv_last, cen_q, cen_d, last_sub, zero_q, zero_d, op_q, op_d;
    logic [2:0] group_q, group_d, subslot_q, subslot_d;
    logic [SLOTS-1:0] slot_q, slot_d;
    jtopl_timing_div #(.N(CENDIV)) u_cdiv (
        .clk(clk), .rst(rst), .halt(halt), .in_en(1'b1), .out_en(cdiv_last)
    );
    // cen_q keeps a pulse pending across halt so it is emitted on release
    assign cen = cen_q && !halt;
    jtopl_timing_div #(.N(OPDIV)) u_odiv (
        .clk(clk), .rst(rst), .halt(halt), .in_en(cen), .out_en(cenop)
    );
    always_comb begin
        cen_d = halt ? cen_q : cdiv_last;
        last_sub = subslot_q == 3'(SUBSLOTS - 1);
        subslot_d = cenop ? (last_sub ? '0 : subslot_q + 3'd1) : subslot_q;
        group_d = (cenop && last_sub) ? (group_q == 3'(GROUPS - 1) ? '0 : group_q + 3'd1) : group_q;
        op_d = subslot_d >= 3'd3;
        zero_d = slot_index(group_d, subslot_d) == 0;
        slot_d = cenop ? {slot_q[SLOTS-2:0], slot_q[SLOTS-1]} : slot_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cen_q     <= 1'b0;
            group_q   <= '0;
            subslot_q <= '0;
            op_q      <= 1'b0;
            zero_q    <= 1'b1;
            slot_q    <= SLOTS'(1);
        end else begin
            cen_q     <= cen_d;
            group_q   <= group_d;
            subslot_q <= subslot_d;
            op_q      <= op_d;
            zero_q    <= zero_d;
            slot_q    <= slot_d;
        end
    assign group = group_q;
    assign subslot = subslot_q;
    assign op = op_q;
    assign zero = zero_q;
    assign slot = slot_q;
`ifdef JTOPL_TIMING_SAMPLE_EN
    logic [15:0] sample_q, sample_d;
    always_comb sample_d = (cenop && last_sub && group_q == 3'(GROUPS - 1)) ? sample_q + 16'd1 : sample_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sample_q <= '0;
        else     sample_q <= sample_d;
    assign sample = sample_q;
`endif
endmodule

// File: tb/tb_jtopl_timing.sv
// tb_jtopl_timing: randomized model-checked bench for jtopl_timing (default and OPL3 fast configs)
module tb_jtopl_timing;
    localparam int CDA = 2, PA = 8, SA = 18;
    localparam int CDB = 1, PB = 1, SB = 36;
    logic clk = 1'b0, rst = 1'b1, halt_a = 1'b0, halt_b = 1'b0;
    logic cen_a, cenop_a, zero_a, op_a, cen_b, cenop_b, zero_b, op_b;
    logic [2:0] group_a, subslot_a, group_b, subslot_b;
    logic [17:0] slot_a;
    logic [35:0] slot_b;
    logic [15:0] sample_a, sample_b;
    logic [45:0] obs_a, obs_b, exp_v;
    int na, nb, compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    jtopl_timing dut_a (
        .clk(clk), .rst(rst), .halt(halt_a), .cen(cen_a), .cenop(cenop_a), .zero(zero_a),
        .group(group_a), .subslot(subslot_a), .op(op_a), .slot(slot_a)
`ifdef JTOPL_TIMING_SAMPLE_EN
        , .sample(sample_a)
`endif
    );
    jtopl_timing #(.GROUPS(6), .CENDIV(1), .OPDIV(1)) dut_b (
        .clk(clk), .rst(rst), .halt(halt_b), .cen(cen_b), .cenop(cenop_b), .zero(zero_b),
        .group(group_b), .subslot(subslot_b), .op(op_b), .slot(slot_b)
`ifdef JTOPL_TIMING_SAMPLE_EN
        , .sample(sample_b)
`endif
    );
`ifndef JTOPL_TIMING_SAMPLE_EN
    assign sample_a = '0;
    assign sample_b = '0;
`endif

    assign obs_a = {cen_a, cenop_a, zero_a, group_a, subslot_a, op_a, 18'd0, slot_a};
    assign obs_b = {cen_b, cenop_b, zero_b, group_b, subslot_b, op_b, slot_b};

    // n = un-halted clock edges since reset release; everything follows from it
    function automatic logic [45:0] model(input int n, input logic h, input int cd, input int per, input int slots);
        int p;
        logic [35:0] s;
        logic c, co;
        p = (n > 0) ? ((n - 1) / per) % slots : 0;
        c = (n > 0) && (n % cd == 0) && !h;
        co = (n > 0) && (n % per == 0) && !h;
        s = 36'd1 << p;
        return {c, co, p == 0, 3'(p / 6), 3'(p % 6), (p % 6) >= 3, s};
    endfunction

    function automatic int frames(input int n, input int per, input int slots);
        return (n > 0) ? (((n - 1) / per) / slots) % 65536 : 0;
    endfunction

    task automatic tick(input logic ha, input logic hb);
        @(posedge clk);
        if (!halt_a) na++;
        if (!halt_b) nb++;
        #1 halt_a = ha;
        halt_b = hb;
        @(negedge clk);
    endtask

    task automatic release_rst;
        @(posedge clk);
        #1 rst = 1'b0;
        na = 0;
        nb = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_v = model(0, 1'b0, CDA, PA, SA);
        compared++;
        if (obs_a !== exp_v) begin mismatched++; $display("FAIL reset_a: got %h expected %h", obs_a, exp_v); end
        exp_v = model(0, 1'b0, CDB, PB, SB);
        compared++;
        if (obs_b !== exp_v) begin mismatched++; $display("FAIL reset_b: got %h expected %h", obs_b, exp_v); end
`ifdef JTOPL_TIMING_SAMPLE_EN
        compared++;
        if (sample_a !== 16'd0) begin mismatched++; $display("FAIL reset_sample: got %h expected 0", sample_a); end
`endif
        release_rst();
    endtask

    task automatic test_free_run;
        for (int i = 0; i < 320; i++) begin
            tick(1'b0, 1'b0);
            exp_v = model(na, halt_a, CDA, PA, SA);
            compared++;
            if (obs_a !== exp_v) begin mismatched++; $display("FAIL run_a n=%0d: got %h expected %h", na, obs_a, exp_v); end
            exp_v = model(nb, halt_b, CDB, PB, SB);
            compared++;
            if (obs_b !== exp_v) begin mismatched++; $display("FAIL run_b n=%0d: got %h expected %h", nb, obs_b, exp_v); end
        end
    endtask

    task automatic test_halt;
        int k;
        while (na % PA != PA - 1) tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            exp_v = model(na, halt_a, CDA, PA, SA);
            compared++;
            if (obs_a !== exp_v || cen_a !== 1'b0 || cenop_a !== 1'b0) begin
                mismatched++; $display("FAIL halt_hold: got %h expected %h", obs_a, exp_v);
            end
        end
        tick(1'b0, 1'b0);
        compared++;
        if (cenop_a !== 1'b1) begin mismatched++; $display("FAIL halt_release: cenop got %b expected 1", cenop_a); end
        k = 0;
        do begin tick(1'b0, 1'b0); k++; end while (!cenop_a && k < 20);
        compared++;
        if (k !== PA) begin mismatched++; $display("FAIL halt_period: got %0d expected %0d", k, PA); end
    endtask

    task automatic test_random_halt;
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
            exp_v = model(na, halt_a, CDA, PA, SA);
            compared++;
            if (obs_a !== exp_v) begin mismatched++; $display("FAIL rand_a n=%0d: got %h expected %h", na, obs_a, exp_v); end
            exp_v = model(nb, halt_b, CDB, PB, SB);
            compared++;
            if (obs_b !== exp_v) begin mismatched++; $display("FAIL rand_b n=%0d: got %h expected %h", nb, obs_b, exp_v); end
`ifdef JTOPL_TIMING_SAMPLE_EN
            compared++;
            if (sample_b !== 16'(frames(nb, PB, SB))) begin
                mismatched++; $display("FAIL rand_sample_b: got %0d expected %0d", sample_b, frames(nb, PB, SB));
            end
`endif
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset;
        int k;
        k = 0;
        while (!(na > 0 && ((na - 1) / PA) % SA == 10 && na % PA == 3) && k < 400) begin tick(1'b0, 1'b0); k++; end
        compared++;
        if (group_a !== 3'd1 || subslot_a !== 3'd4) begin
            mismatched++; $display("FAIL mid_pos: got g=%0d s=%0d expected g=1 s=4", group_a, subslot_a);
        end
        #2 rst = 1'b1;
        #1;
        exp_v = model(0, 1'b0, CDA, PA, SA);
        compared++;
        if (obs_a !== exp_v) begin mismatched++; $display("FAIL mid_reset_a: got %h expected %h", obs_a, exp_v); end
        exp_v = model(0, 1'b0, CDB, PB, SB);
        compared++;
        if (obs_b !== exp_v) begin mismatched++; $display("FAIL mid_reset_b: got %h expected %h", obs_b, exp_v); end
        release_rst();
        k = 0;
        do begin tick(1'b0, 1'b0); k++; end while (!cenop_a && k < 20);
        compared++;
        if (k !== PA) begin mismatched++; $display("FAIL mid_reset_period: got %0d expected %0d", k, PA); end
    endtask

`ifdef JTOPL_TIMING_SAMPLE_EN
    task automatic test_sample;
        #2 rst = 1'b1;
        release_rst();
        while (na < 54 * PA) tick(1'b0, 1'b0);
        compared++;
        if (sample_a !== 16'd2) begin mismatched++; $display("FAIL sample_pre: got %0d expected 2", sample_a); end
        tick(1'b0, 1'b0);
        compared++;
        if (sample_a !== 16'd3) begin mismatched++; $display("FAIL sample_54: got %0d expected 3", sample_a); end
        compared++;
        if (sample_b !== 16'(frames(nb, PB, SB))) begin
            mismatched++; $display("FAIL sample_b: got %0d expected %0d", sample_b, frames(nb, PB, SB));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_halt();
        test_random_halt();
        test_mid_reset();
`ifdef JTOPL_TIMING_SAMPLE_EN
        test_sample();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
